uart_send_sequencer: RTL and testbench

//  Sequences the 256x8 send_buffer RAM and the UART transmitter. The RAM is

---
 rtl/uart_send_sequencer_pkg.sv | 6 +
 rtl/uart_send_sequencer.sv | 76 +++++++
 tb/tb_uart_send_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_send_sequencer_pkg.sv
// uart_send_sequencer_pkg: shared FSM state encoding and default widths
package uart_send_sequencer_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WAIT_ACK, WAIT_DONE} state_e;
endpackage

// File: rtl/uart_send_sequencer.sv
// uart_send_sequencer: circular FIFO over a single-port RAM feeding a UART handshake
module uart_send_sequencer
  import uart_send_sequencer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              tx_data_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic tx_data_ready_q, tx_data_ready_d;
  logic push, pop;
  assign empty = level_q == '0;
  assign full = level_q == DEPTH;
  assign level = level_q;
  assign wr_ready = !full && state_q != RD_ADDR;
  assign push = wr_valid && wr_ready;
  assign pop = state_q == RD_DATA;
  assign ram_write_enable = push;
  assign ram_address = push ? wr_ptr_q : rd_ptr_q;
  assign ram_data_in = wr_data;
  assign tx_data_ready = tx_data_ready_q;
  // RAM output is live during RD_DATA, so present it alongside the pulse
  assign tx_data = tx_data_ready_q ? ram_data_out : tx_data_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = (!empty && !tx_busy) ? RD_ADDR : IDLE;
      RD_ADDR:   state_d = RD_DATA;
      RD_DATA:   state_d = WAIT_ACK;
      WAIT_ACK:  state_d = tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_d = tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, pop};
    level_d = level_q + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    tx_data_d = tx_data_ready_q ? ram_data_out : tx_data_q;
    tx_data_ready_d = state_d == RD_DATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      tx_data_q <= '0;
      tx_data_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      tx_data_q <= tx_data_d;
      tx_data_ready_q <= tx_data_ready_d;
    end
  end
endmodule

// File: tb/tb_uart_send_sequencer.sv
// tb_uart_send_sequencer: RAM + UART models, FIFO scoreboard and directed scenarios
module tb_uart_send_sequencer;
  logic clk = 0, reset = 1, wr_valid = 0, tx_busy = 0, wr_ready;
  logic [7:0] wr_data = 0, ram_data_in, ram_data_out = 0, tx_data;
  logic [7:0] ram_address;
  logic ram_write_enable, tx_data_ready, empty, full;
  logic [8:0] level;
  logic [7:0] mem [256];
  logic [7:0] q [$];
  int errors = 0, checks = 0, cyc = 0, mlevel = 0, mwr = 0, mrd = 0;
  int pulse_cnt = 0, last_pulse_cyc = 0, fall_cyc = 0, gap = 0, acc_cyc = 0, overlap_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] last_data = 0;
  bit have_prev = 0, prev_wr_ready = 0, prev_full = 0, prev_busy = 0, force_busy = 0;

  uart_send_sequencer dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out), .tx_data_ready(tx_data_ready), .tx_data(tx_data),
    .tx_busy(tx_busy), .level(level), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  // UART: busy from the cycle after a pulse, for 10 cycles
  initial forever begin
    bit p;
    @(negedge clk);
    p = tx_data_ready;
    @(posedge clk);
    #1;
    if (p) busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy || busy_cnt > 0;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: FIFO of accepted bytes, level = accepted - popped
  always @(negedge clk) begin
    bit acc;
    cyc++;
    if (reset) begin
      q.delete();
      mlevel = 0; mwr = 0; mrd = 0; have_prev = 0;
    end else begin
      acc = wr_valid && wr_ready;
      chk("level", level, mlevel);
      chk("empty", empty, mlevel == 0);
      chk("full", full, mlevel == 256);
      if (have_prev) chk("wr_ready", prev_wr_ready, !prev_full && !tx_data_ready);
      chk("ram_we", ram_write_enable, acc);
      chk("ram_addr", ram_address, acc ? mwr : mrd);
      if (acc) chk("ram_din", ram_data_in, wr_data);
      if (tx_data_ready) begin
        pulse_cnt++;
        gap = cyc - fall_cyc;
        last_pulse_cyc = cyc;
        last_data = tx_data;
        if (acc) overlap_cnt++;
        chk("busy_at_pulse", tx_busy, 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pulse_when_empty got=pulse expected=no pulse (cycle %0d)", cyc);
        end else chk("tx_data", tx_data, q.pop_front());
        mrd = (mrd + 1) % 256;
      end
      prev_wr_ready = wr_ready;
      prev_full = mlevel == 256;
      have_prev = 1;
      if (acc) begin q.push_back(wr_data); mwr = (mwr + 1) % 256; end
      mlevel = mlevel + int'(acc) - int'(tx_data_ready);
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit ok = 0;
    wr_valid = 1;
    wr_data = d;
    for (int i = 0; i < 2000 && !ok; i++) begin
      sample();
      ok = wr_ready;
      if (ok) acc_cyc = cyc;
      tick();
    end
    chk("push_accepted", ok, 1);
  endtask

  task automatic wait_pulse(input int n);
    for (int i = 0; i < 100 && pulse_cnt < n; i++) sample();
    chk("pulse_timeout", pulse_cnt >= n, 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      sample();
      done = level == 0 && !tx_busy;
    end
    chk("drain_timeout", done, 1);
    tick();
    tick();
  endtask

  initial begin
    int p, p0, ov0;
    logic [7:0] first;
    repeat (3) tick();
    reset = 0;
    sample();
    chk("reset_level", level, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_pulse", tx_data_ready, 0);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_we", ram_write_enable, 0);
    chk("reset_addr", ram_address, 0);
    tick();
    // single byte into empty FIFO
    p0 = pulse_cnt;
    push(8'h43);
    wr_valid = 0;
    sample();
    chk("t1_level1", level, 1);
    wait_pulse(p0 + 1);
    chk("t1_latency", last_pulse_cyc - acc_cyc, 3);
    chk("t1_data", last_data, 8'h43);
    sample();
    chk("t1_level0", level, 0);
    drain();
    chk("t1_single_pulse", pulse_cnt, p0 + 1);
    // three back-to-back bytes
    p = pulse_cnt;
    push(8'h41); push(8'h42); push(8'h43);
    wr_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      wait_pulse(p + i);
      chk("t2_data", last_data, 8'h40 + i);
      if (i > 1) chk("t2_gap", gap, 3);
    end
    drain();
    // fill while the UART is held busy
    force_busy = 1;
    tick(); tick();
    first = 8'($urandom);
    push(first);
    for (int i = 1; i < 256; i++) push(8'($urandom));
    wr_valid = 1;
    wr_data = 8'hEE;
    sample();
    chk("t3_full", full, 1);
    chk("t3_level", level, 256);
    repeat (3) begin sample(); chk("t3_257_blocked", wr_ready, 0); end
    tick();
    wr_valid = 0;
    p = pulse_cnt;
    force_busy = 0;
    wait_pulse(p + 1);
    chk("t3_first_byte", last_data, first);
    drain();
    chk("t3_drained", pulse_cnt - p, 256);
    // 300 bytes with random gaps, pointers wrap
    p = pulse_cnt;
    for (int i = 0; i < 300; i++) begin
      wr_valid = 0;
      repeat ($urandom_range(0, 2)) tick();
      push(8'($urandom));
    end
    wr_valid = 0;
    drain();
    chk("t4_count", pulse_cnt - p, 300);
    // continuous wr_valid
    ov0 = overlap_cnt;
    wr_valid = 1;
    wr_data = 8'($urandom);
    for (int i = 0; i < 80; i++) begin
      bit a;
      sample();
      a = wr_ready;
      tick();
      if (a) wr_data = 8'($urandom);
    end
    wr_valid = 0;
    drain();
    chk("t5_overlap_seen", overlap_cnt > ov0, 1);
    // reset during WAIT_DONE with 5 bytes queued
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    wr_valid = 0;
    sample();
    chk("t6_pre_level", level, 5);
    chk("t6_pre_busy", tx_busy, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    sample();
    chk("t6_level", level, 0);
    chk("t6_empty", empty, 1);
    chk("t6_busy_held", tx_busy, 1);
    p = pulse_cnt;
    repeat (30) sample();
    chk("t6_no_pulse", pulse_cnt, p);
    tick();
    push(8'h5A);
    wr_valid = 0;
    wait_pulse(p + 1);
    chk("t6_new_byte", last_data, 8'h5A);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
